// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown-timer front panel.
// State encoding doubles as the panel LED code, so the values are fixed.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam int CLK_FREQ       = 4_000_000;
  localparam int PRESET_MIN     = 1;
  localparam int PRESET_MAX     = 99;
  localparam int PRESET_DEFAULT = 10;

  localparam int MIN_W  = 7;
  localparam int SEC_W  = 6;
  localparam int TICK_W = 22;
  localparam int BSEC_W = 2;

  // Preset never leaves [PRESET_MIN, max]; both directions wrap.
  function automatic logic [MIN_W-1:0] preset_step(
    input logic [MIN_W-1:0] cur,
    input logic             up,
    input logic [MIN_W-1:0] max
  );
    logic [MIN_W-1:0] nxt;
    if (up) begin
      nxt = (cur >= max) ? MIN_W'(PRESET_MIN) : cur + MIN_W'(1);
    end else begin
      nxt = (cur <= MIN_W'(PRESET_MIN)) ? max : cur - MIN_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF sync -> debounce -> one-cycle rising-edge press pulse.
// Latency 2 + DEBOUNCE_CYC + 1 cycles from raw edge to pulse; no backpressure, pulses are fire-and-forget.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 40_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter measures how long the synchronized level has disagreed with the accepted one.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
      press_q <= level_q & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/timer_ctrl.sv
// Front-panel controller: debounced buttons, minute preset, run/pause/expiry sequencing and buzzer.
// Outputs update one cycle after a press pulse; load is a registered one-cycle strobe; no backpressure.
module timer_ctrl #(
  parameter int CLK_FREQ       = timer_pkg::CLK_FREQ,
  parameter int DEBOUNCE_CYC   = 40_000,
  parameter int PRESET_DEFAULT = timer_pkg::PRESET_DEFAULT,
  parameter int PRESET_MAX     = timer_pkg::PRESET_MAX,
  parameter int BUZZ_SEC       = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn_sp,
  input  logic                        btn_clr,
  input  logic                        btn_inc,
  input  logic                        btn_dec,
  input  logic [timer_pkg::MIN_W-1:0] minute,
  input  logic [timer_pkg::SEC_W-1:0] second,
  output logic                        pause,
  output logic                        load,
  output logic [timer_pkg::MIN_W-1:0] load_minute,
  output logic                        buzzer,
  output logic [1:0]                  state
);

  import timer_pkg::*;

  localparam logic [MIN_W-1:0]  PMAX      = MIN_W'(PRESET_MAX);
  localparam logic [MIN_W-1:0]  PDEF      = MIN_W'(PRESET_DEFAULT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_FREQ - 1);
  localparam logic [BSEC_W-1:0] BSEC_LAST = BSEC_W'(BUZZ_SEC - 1);

  logic sp_p, clr_p, inc_p, dec_p;
  logic ev_sp, ev_clr, ev_inc, ev_dec, ev_any;

  state_e             state_q, state_d;
  logic [MIN_W-1:0]   preset_q, preset_d;
  logic               load_q, load_d;
  logic               pause_q, pause_d;
  logic               buzzer_q, buzzer_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [BSEC_W-1:0]  bsec_q, bsec_d;
  logic               zero_q;
  logic               init_q;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sp (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_sp), .press_o(sp_p)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_clr), .press_o(clr_p)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_inc), .press_o(inc_p)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dec (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_dec), .press_o(dec_p)
  );

  // Only the highest-priority press of a cycle survives.
  assign ev_sp  = sp_p;
  assign ev_clr = clr_p & ~sp_p;
  assign ev_inc = inc_p & ~sp_p & ~clr_p;
  assign ev_dec = dec_p & ~sp_p & ~clr_p & ~inc_p;
  assign ev_any = sp_p | clr_p | inc_p | dec_p;

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    load_d   = init_q;
    buzzer_d = buzzer_q;
    tick_d   = tick_q;
    bsec_d   = bsec_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ev_sp) begin
          state_d = ST_RUN;
        end else if (ev_clr) begin
          load_d = 1'b1;
        end else if (ev_inc || ev_dec) begin
          preset_d = preset_step(preset_q, ev_inc, PMAX);
          load_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (ev_sp) begin
          state_d = ST_PAUSED;
        end else if (zero_q) begin
          state_d  = ST_EXPIRED;
          buzzer_d = 1'b1;
          tick_d   = '0;
          bsec_d   = '0;
        end
      end
      ST_PAUSED: begin
        if (ev_sp) begin
          state_d = ST_RUN;
        end else if (ev_clr) begin
          state_d = ST_IDLE;
          load_d  = 1'b1;
        end
      end
      ST_EXPIRED: begin
        if (ev_any) begin
          state_d  = ST_IDLE;
          buzzer_d = 1'b0;
          load_d   = 1'b1;
        end else if (buzzer_q) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (bsec_q == BSEC_LAST) begin
              buzzer_d = 1'b0;
            end else begin
              bsec_d = bsec_q + BSEC_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pause_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      preset_q <= PDEF;
      load_q   <= 1'b0;
      pause_q  <= 1'b1;
      buzzer_q <= 1'b0;
      tick_q   <= '0;
      bsec_q   <= '0;
      zero_q   <= 1'b0;
      init_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      load_q   <= load_d;
      pause_q  <= pause_d;
      buzzer_q <= buzzer_d;
      tick_q   <= tick_d;
      bsec_q   <= bsec_d;
      zero_q   <= (minute == '0) && (second == '0);
      init_q   <= 1'b0;
    end
  end

  assign state       = state_q;
  assign pause       = pause_q;
  assign load        = load_q;
  assign load_minute = preset_q;
  assign buzzer      = buzzer_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl with a small clock and debounce so full sequences run in a few thousand cycles.
module tb_timer_ctrl;

  localparam int CF = 100;
  localparam int DB = 4;
  localparam int BZ = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_sp = 1'b0, btn_clr = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [6:0] minute = 7'd10;
  logic [5:0] second = 6'd0;
  logic       pause, load, buzzer;
  logic [6:0] load_minute;
  logic [1:0] state;

  int total = 0;
  int bad = 0;
  int load_cnt = 0;
  int dbl_cnt = 0;
  logic load_prev = 1'b0;

  int mdl_state;
  int mdl_preset;
  int exp_loads;

  timer_ctrl #(
    .CLK_FREQ(CF), .DEBOUNCE_CYC(DB), .PRESET_DEFAULT(10), .PRESET_MAX(99), .BUZZ_SEC(BZ)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_sp(btn_sp), .btn_clr(btn_clr), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .minute(minute), .second(second),
    .pause(pause), .load(load), .load_minute(load_minute),
    .buzzer(buzzer), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && load === 1'b1) begin
      load_cnt <= load_cnt + 1;
      if (load_prev === 1'b1) dbl_cnt <= dbl_cnt + 1;
    end
    load_prev <= load;
  end

  // Reference: the panel rules applied to one accepted press event.
  task automatic model_press(input logic [3:0] m);
    int ev;
    ev = m[3] ? 0 : m[2] ? 1 : m[1] ? 2 : m[0] ? 3 : 4;
    case (mdl_state)
      0: begin
        if (ev == 0) mdl_state = 1;
        else if (ev == 1) exp_loads++;
        else if (ev == 2) begin mdl_preset = (mdl_preset % 99) + 1; exp_loads++; end
        else if (ev == 3) begin mdl_preset = ((mdl_preset + 97) % 99) + 1; exp_loads++; end
      end
      1: if (ev == 0) mdl_state = 2;
      2: begin
        if (ev == 0) mdl_state = 1;
        else if (ev == 1) begin mdl_state = 0; exp_loads++; end
      end
      default: if (ev != 4) begin mdl_state = 0; exp_loads++; end
    endcase
  endtask

  task automatic press(input logic [3:0] m);
    @(posedge clk); #1;
    {btn_sp, btn_clr, btn_inc, btn_dec} = m;
    repeat (10) @(posedge clk);
    #1;
    {btn_sp, btn_clr, btn_inc, btn_dec} = 4'b0000;
    repeat (10) @(posedge clk);
    model_press(m);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL rst_pause got=%b want=1", pause); end
    total++; if (load !== 1'b0) begin bad++; $display("FAIL rst_load got=%b want=0", load); end
    total++; if (buzzer !== 1'b0) begin bad++; $display("FAIL rst_buzzer got=%b want=0", buzzer); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
    total++; if (load_minute !== 7'd10) begin bad++; $display("FAIL rst_lm got=%0d want=10", load_minute); end
    rst_n = 1'b1;
    mdl_state = 0; mdl_preset = 10; exp_loads = 1;
    @(negedge clk);
    total++; if (load !== 1'b1) begin bad++; $display("FAIL post_rst_load got=%b want=1", load); end
    total++; if (load_minute !== 7'd10) begin bad++; $display("FAIL post_rst_lm got=%0d want=10", load_minute); end
    @(negedge clk);
    total++; if (load !== 1'b0) begin bad++; $display("FAIL post_rst_load_fall got=%b want=0", load); end
    repeat (3) @(negedge clk);
    total++; if (load_cnt !== exp_loads) begin bad++; $display("FAIL post_rst_cnt got=%0d want=%0d", load_cnt, exp_loads); end
  endtask

  task automatic test_preset_wrap;
    logic [3:0] seq [$];
    for (int i = 0; i < 3; i++) seq.push_back(4'b0010);
    for (int i = 0; i < 13; i++) seq.push_back(4'b0001);
    seq.push_back(4'b0010);
    foreach (seq[i]) begin
      press(seq[i]);
      @(negedge clk);
      total++; if (load_minute !== 7'(mdl_preset)) begin bad++; $display("FAIL wrap_lm[%0d] got=%0d want=%0d", i, load_minute, mdl_preset); end
      total++; if (load_cnt !== exp_loads) begin bad++; $display("FAIL wrap_loads[%0d] got=%0d want=%0d", i, load_cnt, exp_loads); end
      if (i == 15) begin
        total++; if (load_minute !== 7'd99) begin bad++; $display("FAIL wrap_dec_to_99 got=%0d want=99", load_minute); end
      end
    end
    @(posedge clk); #1 btn_inc = 1'b1;
    repeat (2) @(posedge clk);
    #1 btn_inc = 1'b0;
    repeat (15) @(negedge clk);
    total++; if (load_cnt !== exp_loads) begin bad++; $display("FAIL glitch_loads got=%0d want=%0d", load_cnt, exp_loads); end
    total++; if (load_minute !== 7'(mdl_preset)) begin bad++; $display("FAIL glitch_lm got=%0d want=%0d", load_minute, mdl_preset); end
  endtask

  task automatic test_start_pause;
    logic [3:0] seq [$];
    @(posedge clk); #1 btn_sp = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL sp_latency_early got=%0d want=0", state); end
    @(negedge clk);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL sp_latency got=%0d want=1", state); end
    total++; if (pause !== 1'b0) begin bad++; $display("FAIL sp_pause got=%b want=0", pause); end
    btn_sp = 1'b0;
    repeat (12) @(posedge clk);
    model_press(4'b1000);
    seq = '{4'b0100, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b0100};
    foreach (seq[i]) begin
      press(seq[i]);
      @(negedge clk);
      total++; if (state !== 2'(mdl_state)) begin bad++; $display("FAIL seq_state[%0d] got=%0d want=%0d", i, state, mdl_state); end
      total++; if (pause !== (mdl_state != 1)) begin bad++; $display("FAIL seq_pause[%0d] got=%b want=%b", i, pause, mdl_state != 1); end
      total++; if (load_cnt !== exp_loads) begin bad++; $display("FAIL seq_loads[%0d] got=%0d want=%0d", i, load_cnt, exp_loads); end
      total++; if (load_minute !== 7'(mdl_preset)) begin bad++; $display("FAIL seq_lm[%0d] got=%0d want=%0d", i, load_minute, mdl_preset); end
    end
  endtask

  task automatic test_random;
    logic [3:0] m;
    for (int i = 0; i < 30; i++) begin
      minute = 7'($urandom_range(1, 99));
      second = 6'($urandom_range(0, 59));
      m = 4'($urandom_range(1, 15));
      press(m);
      @(negedge clk);
      total++; if (state !== 2'(mdl_state)) begin bad++; $display("FAIL rnd_state[%0d] m=%b got=%0d want=%0d", i, m, state, mdl_state); end
      total++; if (pause !== (mdl_state != 1)) begin bad++; $display("FAIL rnd_pause[%0d] got=%b want=%b", i, pause, mdl_state != 1); end
      total++; if (load_cnt !== exp_loads) begin bad++; $display("FAIL rnd_loads[%0d] got=%0d want=%0d", i, load_cnt, exp_loads); end
      total++; if (load_minute !== 7'(mdl_preset)) begin bad++; $display("FAIL rnd_lm[%0d] got=%0d want=%0d", i, load_minute, mdl_preset); end
    end
    if (mdl_state == 1) press(4'b1000);
    if (mdl_state == 2) press(4'b0100);
  endtask

  task automatic test_expiry;
    int n;
    press(4'b1000);
    @(posedge clk); #1;
    minute = 7'd0; second = 6'd0;
    @(posedge clk);
    @(negedge clk);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL exp_early_state got=%0d want=1", state); end
    @(negedge clk);
    total++; if (state !== 2'd3) begin bad++; $display("FAIL exp_state got=%0d want=3", state); end
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL exp_pause got=%b want=1", pause); end
    total++; if (buzzer !== 1'b1) begin bad++; $display("FAIL exp_buzz_on got=%b want=1", buzzer); end
    mdl_state = 3;
    n = 1;
    for (int i = 0; i < 1000 && buzzer === 1'b1; i++) begin
      @(negedge clk);
      if (buzzer === 1'b1) n++;
    end
    total++; if (n !== BZ * CF) begin bad++; $display("FAIL buzz_len got=%0d want=%0d", n, BZ * CF); end
    repeat (20) @(negedge clk);
    total++; if (buzzer !== 1'b0) begin bad++; $display("FAIL buzz_off got=%b want=0", buzzer); end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL exp_hold got=%0d want=3", state); end
    minute = 7'd7; second = 6'd30;
    press(4'b0001);
    @(negedge clk);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL exp_exit_state got=%0d want=0", state); end
    total++; if (load_cnt !== exp_loads) begin bad++; $display("FAIL exp_exit_loads got=%0d want=%0d", load_cnt, exp_loads); end
    total++; if (load_minute !== 7'(mdl_preset)) begin bad++; $display("FAIL exp_exit_lm got=%0d want=%0d", load_minute, mdl_preset); end
  endtask

  task automatic test_simultaneous;
    press(4'b1010);
    @(negedge clk);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL simul_state got=%0d want=1", state); end
    total++; if (load_minute !== 7'(mdl_preset)) begin bad++; $display("FAIL simul_lm got=%0d want=%0d", load_minute, mdl_preset); end
    total++; if (load_cnt !== exp_loads) begin bad++; $display("FAIL simul_loads got=%0d want=%0d", load_cnt, exp_loads); end
    press(4'b1000);
    press(4'b0100);
    @(negedge clk);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL simul_back_idle got=%0d want=0", state); end
  endtask

  task automatic test_reset_mid;
    if (mdl_preset == 10) press(4'b0010);
    press(4'b1000);
    @(posedge clk); #1;
    minute = 7'd0; second = 6'd0;
    repeat (6) @(negedge clk);
    total++; if (buzzer !== 1'b1) begin bad++; $display("FAIL mid_buzz_on got=%b want=1", buzzer); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (buzzer !== 1'b0) begin bad++; $display("FAIL mid_buzz_rst got=%b want=0", buzzer); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL mid_state_rst got=%0d want=0", state); end
    total++; if (load_minute !== 7'd10) begin bad++; $display("FAIL mid_preset_rst got=%0d want=10", load_minute); end
    minute = 7'd9;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mdl_state = 0; mdl_preset = 10; exp_loads++;
    @(negedge clk);
    total++; if (load !== 1'b1) begin bad++; $display("FAIL mid_post_load got=%b want=1", load); end
    repeat (4) @(negedge clk);
    total++; if (load_cnt !== exp_loads) begin bad++; $display("FAIL mid_loads got=%0d want=%0d", load_cnt, exp_loads); end
    total++; if (dbl_cnt !== 0) begin bad++; $display("FAIL load_width got=%0d want=0", dbl_cnt); end
  endtask

  initial begin
    test_reset();
    test_preset_wrap();
    test_start_pause();
    test_random();
    test_expiry();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
